// File: rtl/intc_pkg.sv
// Shared constants for the interrupt controller: register offsets, CLAIM layout, source id type.
package intc_pkg;
  localparam logic [31:0] INTC_PEND_OFS  = 32'h0;
  localparam logic [31:0] INTC_MASK_OFS  = 32'h4;
  localparam logic [31:0] INTC_CLAIM_OFS = 32'h8;
  localparam logic [31:0] INTC_RAW_OFS   = 32'hC;
  localparam int          CLAIM_VALID_BIT = 31;

  typedef logic [4:0] src_id_t;
endpackage

// File: rtl/intr_ctrl_if.sv
// IOBUS slice seen by the interrupt controller: address, write data/strobe, read data.
interface intr_ctrl_if;
  logic [31:0] iobus_addr;
  logic [31:0] iobus_out;
  logic        iobus_wr;
  logic [31:0] iobus_in;

  modport master (output iobus_addr, iobus_out, iobus_wr, input iobus_in);
  modport slave  (input iobus_addr, iobus_out, iobus_wr, output iobus_in);
endinterface

// File: rtl/intr_src_cond.sv
// Per-source conditioning: 2-flop sync, optional counter debounce (INTC_DEBOUNCE_EN),
// armed-gated rising-edge pulse.
module intr_src_cond #(
  parameter logic [15:0] DB_CYCLES = 16'd50000
) (
  input  logic clk,
  input  logic rst,
  input  logic src,
  input  logic armed,
  output logic level,
  output logic rise
);
  logic sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;

  always_comb begin
    sync1_d = src;
    sync2_d = sync1_q;
    prev_d  = level;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

`ifdef INTC_DEBOUNCE_EN
  logic [15:0] cnt_q, cnt_d;
  logic        filt_q, filt_d;

  // Until armed the filter tracks the input directly so a level held through reset
  // settles without ever looking like an edge.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (!armed) begin
      filt_d = sync2_q;
    end else if (sync2_q != filt_q) begin
      if (cnt_q == DB_CYCLES - 16'd1) filt_d = sync2_q;
      else                            cnt_d  = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign level = filt_q;
`else
  assign level = sync2_q;
`endif

  assign rise = armed & level & ~prev_q;
endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller: per-source pend latches, mask, IOBUS PEND/MASK/CLAIM/RAW, registered intr.
// Define INTC_DEBOUNCE_EN to insert a DB_CYCLES counter filter after each synchronizer.
module intr_ctrl
  import intc_pkg::*;
#(
  parameter int          N_SRC     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h1100E000,
  parameter logic [15:0] DB_CYCLES = 16'd50000
) (
  input  logic             clk,
  input  logic             RST,
  input  logic [N_SRC-1:0] src,
  intr_ctrl_if.slave       bus,
  output logic             intr
);
  // Arm only once the sync (and filter) pipeline holds real samples, so a source
  // already high at reset release is absorbed into prev instead of reported.
`ifdef INTC_DEBOUNCE_EN
  localparam int ARM_STAGES = 4;
`else
  localparam int ARM_STAGES = 3;
`endif

  logic [ARM_STAGES-1:0] vld_pipe_q, vld_pipe_d;
  logic                  armed;
  logic [N_SRC-1:0]      level, rise;
  logic [N_SRC-1:0]      pend_q, pend_d, mask_q, mask_d, active;
  logic                  intr_q, intr_d;
  logic                  sel_pend, sel_mask, sel_claim, sel_raw;
  src_id_t               claim_id;

  assign vld_pipe_d = {vld_pipe_q[ARM_STAGES-2:0], 1'b1};
  assign armed      = vld_pipe_q[ARM_STAGES-1];

  for (genvar g = 0; g < N_SRC; g++) begin : g_src
    intr_src_cond #(.DB_CYCLES(DB_CYCLES)) u_cond (
      .clk   (clk),
      .rst   (RST),
      .src   (src[g]),
      .armed (armed),
      .level (level[g]),
      .rise  (rise[g])
    );
  end

  assign sel_pend  = bus.iobus_addr == BASE_ADDR + INTC_PEND_OFS;
  assign sel_mask  = bus.iobus_addr == BASE_ADDR + INTC_MASK_OFS;
  assign sel_claim = bus.iobus_addr == BASE_ADDR + INTC_CLAIM_OFS;
  assign sel_raw   = bus.iobus_addr == BASE_ADDR + INTC_RAW_OFS;
  assign active    = pend_q & mask_q;

  // Descending scan: the last hit, i.e. the lowest index, wins.
  always_comb begin
    claim_id = '0;
    for (int i = N_SRC - 1; i >= 0; i--)
      if (active[i]) claim_id = src_id_t'(i);
  end

  always_comb begin
    pend_d = pend_q;
    mask_d = mask_q;
    if (bus.iobus_wr && sel_pend) pend_d = pend_q & ~bus.iobus_out[N_SRC-1:0];
    if (bus.iobus_wr && sel_mask) mask_d = bus.iobus_out[N_SRC-1:0];
    pend_d = pend_d | rise;
    intr_d = |active;
  end

  always_comb begin
    bus.iobus_in = '0;
    if (sel_pend) bus.iobus_in[N_SRC-1:0] = pend_q;
    if (sel_mask) bus.iobus_in[N_SRC-1:0] = mask_q;
    if (sel_raw)  bus.iobus_in[N_SRC-1:0] = level;
    if (sel_claim) begin
      bus.iobus_in[CLAIM_VALID_BIT] = |active;
      bus.iobus_in[4:0]             = claim_id;
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      vld_pipe_q <= '0;
      pend_q     <= '0;
      mask_q     <= '0;
      intr_q     <= 1'b0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      pend_q     <= pend_d;
      mask_q     <= mask_d;
      intr_q     <= intr_d;
    end
  end

  assign intr = intr_q;
endmodule

// File: tb/tb_intr_ctrl.sv
// Scoreboarded bench for intr_ctrl: reset arming, latency, W1C, CLAIM priority, decode, mid-run reset.
module tb_intr_ctrl;
  import intc_pkg::*;

  localparam int          N    = 4;
  localparam logic [31:0] BASE = 32'h1100E000;
`ifdef INTC_DEBOUNCE_EN
  localparam int EX = 8;
`else
  localparam int EX = 0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] src = '0;
  logic         intr;

  intr_ctrl_if bus ();

  intr_ctrl #(.N_SRC(N), .BASE_ADDR(BASE), .DB_CYCLES(16'd8)) dut (
    .clk  (clk),
    .RST  (rst),
    .src  (src),
    .bus  (bus),
    .intr (intr)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd_exp(input string tag, input logic [31:0] ofs, input logic [31:0] exp);
    exp_t e;
    sb.push_back('{tag, exp});
    bus.iobus_addr = BASE + ofs;
    #1;
    e = sb.pop_front();
    chk(e.tag, bus.iobus_in, e.val);
  endtask

  task automatic intr_exp(input string tag, input logic exp);
    exp_t e;
    sb.push_back('{tag, {31'b0, exp}});
    #1;
    e = sb.pop_front();
    chk(e.tag, {31'b0, intr}, e.val);
  endtask

  task automatic wr(input logic [31:0] ofs, input logic [31:0] data);
    bus.iobus_addr = BASE + ofs;
    bus.iobus_out  = data;
    bus.iobus_wr   = 1'b1;
    @(posedge clk);
    #1;
    bus.iobus_wr   = 1'b0;
    bus.iobus_out  = '0;
  endtask

  initial begin
    bus.iobus_addr = '0;
    bus.iobus_out  = '0;
    bus.iobus_wr   = 1'b0;

    // source high through reset must not pend
    src = 4'b0010;
    tick(3);
    rst = 1'b0;
    tick(10 + EX);
    rd_exp("rst_pend", INTC_PEND_OFS, 32'h0);
    intr_exp("rst_intr", 1'b0);
    rd_exp("rst_raw", INTC_RAW_OFS, 32'h2);
    src = '0;
    tick(4 + EX);

    // rise latency: pend after k+2, intr after k+3
    wr(INTC_MASK_OFS, 32'hF);
    src = 4'b0010;
    tick(2);
    rd_exp("lat_pend_k1", INTC_PEND_OFS, 32'h0);
    tick(1 + EX);
    rd_exp("lat_pend_k2", INTC_PEND_OFS, 32'h2);
    intr_exp("lat_intr_k2", 1'b0);
    tick(1);
    intr_exp("lat_intr_k3", 1'b1);
    rd_exp("claim1", INTC_CLAIM_OFS, 32'h8000_0001);

    // mask gates claim; W1C drops intr one cycle later
    src = 4'b1010;
    tick(4 + EX);
    rd_exp("pend_a", INTC_PEND_OFS, 32'hA);
    wr(INTC_MASK_OFS, 32'h8);
    rd_exp("claim3", INTC_CLAIM_OFS, 32'h8000_0003);
    wr(INTC_PEND_OFS, 32'h8);
    intr_exp("w1c_intr_same", 1'b1);
    tick(1);
    intr_exp("w1c_intr_next", 1'b0);
    rd_exp("w1c_pend", INTC_PEND_OFS, 32'h2);

    // edge and W1C of the same bit in one cycle: set wins
    src = 4'b1110;
    tick(2 + EX);
    wr(INTC_PEND_OFS, 32'h4);
    rd_exp("race_pend", INTC_PEND_OFS, 32'h6);
    wr(INTC_MASK_OFS, 32'h0);
    tick(1);
    intr_exp("race_intr_masked", 1'b0);
    rd_exp("race_pend_masked", INTC_PEND_OFS, 32'h6);

    // reset mid-operation
    src = '0;
    tick(4 + EX);
    src = 4'hF;
    tick(4 + EX);
    wr(INTC_MASK_OFS, 32'hF);
    tick(1);
    intr_exp("pre_rst_intr", 1'b1);
    rd_exp("pre_rst_pend", INTC_PEND_OFS, 32'hF);
    rst = 1'b1;
    tick(1);
    rd_exp("mrst_pend", INTC_PEND_OFS, 32'h0);
    rd_exp("mrst_mask", INTC_MASK_OFS, 32'h0);
    rd_exp("mrst_claim", INTC_CLAIM_OFS, 32'h0);
    rd_exp("mrst_raw", INTC_RAW_OFS, 32'h0);
    intr_exp("mrst_intr", 1'b0);
    rst = 1'b0;
    tick(10 + EX);
    rd_exp("mrst_held_pend", INTC_PEND_OFS, 32'h0);

    // index 0 claim, ignored writes, non-decoded addresses
    src = '0;
    tick(4 + EX);
    src = 4'b0101;
    tick(4 + EX);
    rd_exp("pend_5", INTC_PEND_OFS, 32'h5);
    wr(INTC_MASK_OFS, 32'h5);
    rd_exp("claim0", INTC_CLAIM_OFS, 32'h8000_0000);
    wr(32'h10, 32'hF);
    wr(32'h2, 32'hF);
    wr(INTC_CLAIM_OFS, 32'hF);
    wr(INTC_RAW_OFS, 32'hF);
    rd_exp("nodec_pend", INTC_PEND_OFS, 32'h5);
    rd_exp("nodec_mask", INTC_MASK_OFS, 32'h5);
    bus.iobus_addr = BASE + 32'h10;
    #1;
    chk("nodec_read", bus.iobus_in, 32'h0);

`ifdef INTC_DEBOUNCE_EN
    // short glitch filtered; stable rise delayed by the filter window
    src = '0;
    tick(20);
    wr(INTC_PEND_OFS, 32'hF);
    src = 4'b0001;
    tick(5);
    src = '0;
    tick(20);
    rd_exp("db_glitch", INTC_PEND_OFS, 32'h0);
    src = 4'b0001;
    tick(2 + EX);
    rd_exp("db_lat_early", INTC_PEND_OFS, 32'h0);
    tick(1);
    rd_exp("db_lat", INTC_PEND_OFS, 32'h1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
